// File: rtl/vga_pkg.sv
// Shared raster-timing defaults and colour constants for the VGA pattern pipeline.
// The default timing is 640x480@60 Hz with a 25 MHz pixel clock.
package vga_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Each colour is 6 bits wide and packed as RR_GG_BB.
  typedef enum logic [5:0] {
    RGB_BLACK   = 6'b00_00_00,
    RGB_BLUE    = 6'b00_00_11,
    RGB_GREEN   = 6'b00_11_00,
    RGB_CYAN    = 6'b00_11_11,
    RGB_RED     = 6'b11_00_00,
    RGB_MAGENTA = 6'b11_00_11,
    RGB_YELLOW  = 6'b11_11_00,
    RGB_GREY    = 6'b10_10_10,
    RGB_WHITE   = 6'b11_11_11
  } rgb_e;

  function automatic logic sync_level(input logic pol, input logic in_window);
    return in_window ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis. It holds a registered count, exposes the next count
// and a wrap flag, and registers the sync pulse decoded from the next count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL      = DEF_H_TOTAL,
  parameter int unsigned SYNC_START = DEF_H_ACTIVE + DEF_H_FRONT,
  parameter int unsigned SYNC_LEN   = DEF_H_SYNC,
  parameter bit          SYNC_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             wrap,
  output logic             sync
);

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] S_FIRST = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] S_LAST  = CNT_W'(SYNC_START + SYNC_LEN - 1);

  assign wrap = (cnt == LAST);

  always_comb begin
    cnt_nxt = cnt;
    if (en) cnt_nxt = wrap ? '0 : cnt + 1'b1;
  end

  // Decoding sync from cnt_nxt keeps the registered pulse aligned with the registered count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sync <= ~SYNC_POL;
    end else begin
      cnt  <= cnt_nxt;
      sync <= sync_level(SYNC_POL, (cnt_nxt >= S_FIRST) && (cnt_nxt <= S_LAST));
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator. It produces the x/y coordinates, the sync pulses, the display
// enable, a one-clock next_frame strobe and a frame counter, and every output is registered.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       next_frame,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_M1 = CNT_W'(V_ACTIVE - 1);

  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             h_wrap;
  logic             v_wrap;
  logic             v_en;
  logic             frame_start;

  assign v_en = pix_en & h_wrap;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_ACTIVE + H_FRONT),
    .SYNC_LEN   (H_SYNC),
    .SYNC_POL   (SYNC_POL)
  ) u_h (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (pix_en),
    .cnt     (x),
    .cnt_nxt (h_nxt),
    .wrap    (h_wrap),
    .sync    (hsync)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_ACTIVE + V_FRONT),
    .SYNC_LEN   (V_SYNC),
    .SYNC_POL   (SYNC_POL)
  ) u_v (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (v_en),
    .cnt     (y),
    .cnt_nxt (v_nxt),
    .wrap    (v_wrap),
    .sync    (vsync)
  );

  // The only entry into line V_ACTIVE is the line wrap that leaves line V_ACTIVE-1.
  assign frame_start = v_en & (y == V_ACT_M1);

  // next_frame needs no hold term. The edge after a strobe always has x == 0, so
  // frame_start is low on that edge and the strobe clears whatever pix_en is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      display_on  <= 1'b1;
      next_frame  <= 1'b0;
      frame_count <= '0;
    end else begin
      display_on <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      next_frame <= frame_start;
      if (frame_start) frame_count <= frame_count + 8'd1;
    end
  end

  a_frame_wrap: assert property (@(posedge clk) disable iff (!rst_n)
    (v_en && v_wrap) |=> (y == '0));

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen, built with a compact raster (14x7) so that many frames fit in the run.
module tb_vga_timing_gen;

  localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 1;
  localparam int unsigned VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int unsigned HT = 14, VT = 7;
  localparam int unsigned FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic [9:0] x, y;
  logic       hsync, vsync, display_on, next_frame;
  logic [7:0] frame_count;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .SYNC_POL (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .x           (x),
    .y           (y),
    .hsync       (hsync),
    .vsync       (vsync),
    .display_on  (display_on),
    .next_frame  (next_frame),
    .frame_count (frame_count)
  );

  typedef struct {
    logic [9:0] x, y;
    logic       hs, vs, de, nf;
    logic [7:0] fc;
  } exp_t;

  exp_t sb[$];

  int total = 0, bad = 0;
  int cyc = 0, last_nf = 0, exp_ivl = 0;
  int unsigned mx = 0, my = 0;
  logic [7:0] mfc = '0;
  logic       mnf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mfc = '0; mnf = 1'b0;
    sb.delete();
  endtask

  task automatic model_edge(input logic en);
    mnf = 1'b0;
    if (en) begin
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
      if (mx == 0 && my == VA) begin
        mnf = 1'b1;
        mfc++;
      end
    end
  endtask

  function automatic exp_t expect_now();
    exp_t e;
    e.x  = 10'(mx);
    e.y  = 10'(my);
    e.hs = (mx >= HA + HF && mx < HA + HF + HS) ? 1'b0 : 1'b1;
    e.vs = (my >= VA + VF && my < VA + VF + VS) ? 1'b0 : 1'b1;
    e.de = (mx < HA) && (my < VA);
    e.nf = mnf;
    e.fc = mfc;
    return e;
  endfunction

  task automatic check_out();
    exp_t e;
    chk("sb_depth", 32'(sb.size()), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("x", x, e.x);
      chk("y", y, e.y);
      chk("hsync", hsync, e.hs);
      chk("vsync", vsync, e.vs);
      chk("display_on", display_on, e.de);
      chk("next_frame", next_frame, e.nf);
      chk("frame_count", frame_count, e.fc);
    end
    if (next_frame === 1'b1) begin
      if (exp_ivl != 0) chk("nf_interval", cyc - last_nf, exp_ivl);
      last_nf = cyc;
    end
  endtask

  task automatic step(input logic en);
    pix_en = en;
    @(posedge clk);
    cyc++;
    model_edge(en);
    sb.push_back(expect_now());
    #1;
    check_out();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_hsync"}, hsync, 1);
    chk({tag, "_vsync"}, vsync, 1);
    chk({tag, "_display_on"}, display_on, 1);
    chk({tag, "_next_frame"}, next_frame, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    pix_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    model_reset();
    #2 rst_n = 1'b1;

    // The first strobe after reset release comes VA lines later, then once per frame.
    last_nf = cyc;
    exp_ivl = VA * HT;
    repeat (60) step(1'b1);
    exp_ivl = FRAME;
    repeat (2 * FRAME) step(1'b1);

    // Assert the asynchronous reset in the middle of a line, between clock edges.
    n = 0;
    while (!(mx == 5 && my == 2) && n < 200) begin
      step(1'b1);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    model_reset();
    #2 rst_n = 1'b1;
    last_nf = cyc;
    exp_ivl = VA * HT;
    repeat (60) step(1'b1);
    exp_ivl = FRAME;

    // Run enough frames for frame_count to wrap past 255.
    repeat (256 * FRAME) step(1'b1);

    // Half-rate pixel enable: the strobe interval doubles but the strobe width stays one clock.
    exp_ivl = 0;
    for (int i = 0; i < 2 * FRAME; i++) step(i % 2 == 0);
    exp_ivl = 2 * FRAME;
    for (int i = 0; i < 4 * FRAME; i++) step(i % 2 == 0);

    exp_ivl = 0;
    repeat (300) step(1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Upstream raster-timing stage that drives every pattern generator in the design. It produces the pixel coordinates x/y, the VGA hsync/vsync pulses, a display-enable, and a one-cycle next_frame strobe that pattern blocks use to advance their animation counters. Default timing is 640x480@60 Hz from a 25.175 MHz (nominally 25 MHz) pixel clock. A pixel-enable input allows operation from a faster system clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low, per 640x480 standard)

Ports:
clk  in  1  pixel/system clock
rst_n  in  1  asynchronous active-low reset
pix_en  in  1  pixel advance enable; tie high when clk is the pixel clock
x  out  10  horizontal counter, 0..H_TOTAL-1
y  out  10  vertical counter, 0..V_TOTAL-1
hsync  out  1  horizontal sync, level per SYNC_POL
vsync  out  1  vertical sync, level per SYNC_POL
display_on  out  1  high when x<H_ACTIVE and y<V_ACTIVE
next_frame  out  1  single-clk strobe at the start of vertical blanking
frame_count  out  8  frames completed, wraps at 256

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n); every flop clears on rst_n low, independent of clk.
- H_TOTAL = sum of the H_* parameters (default 800); V_TOTAL = sum of the V_* parameters (default 525).
- Reset values: x=0, y=0, hsync=vsync=inactive (~SYNC_POL), display_on=1 (consistent with position 0,0), next_frame=0, frame_count=0.
- All outputs are registered. hsync, vsync, display_on and next_frame are decoded from the next counter values, so they are cycle-aligned with x/y. There is no combinational path from pix_en to any output.
- Counters advance only on clk edges where pix_en=1. With pix_en=0, x, y, hsync, vsync, display_on and frame_count hold.
- Horizontal: x increments each enabled cycle. At x=H_TOTAL-1, x wraps to 0 and y increments.
- Vertical: at y=V_TOTAL-1 together with an x wrap, y wraps to 0.
- hsync is active for x in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] (default 656..751, 96 pixels).
- vsync is active for y in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1] (default 490..491). vsync is a function of y only, for the whole line.
- next_frame:
  - Asserted for exactly one clk cycle, on the enabled edge where the counters move to (x=0, y=V_ACTIVE).
  - Cleared on the following clk edge regardless of pix_en, so it never stretches when pix_en is sparse.
  - Exactly one pulse per frame.
- frame_count increments (mod 256) on the same edge that sets next_frame, so the new value is visible alongside the strobe.
- Counter width: 10 bits; H_TOTAL and V_TOTAL must be ≤1024. Comparisons use full 10-bit values with no truncation.
- Reset mid-frame: outputs return immediately to reset values. The first post-reset next_frame occurs V_ACTIVE lines after release.
- Downstream pattern blocks are combinational on x/y and must be registered in the top with one cycle. The top delays hsync/vsync/display_on by one matching cycle; that delay is not part of this block.

Decomposition:
- Shared package vga_pkg holds default timing constants (H_ACTIVE..V_BACK, H_TOTAL, V_TOTAL) and the 6-bit RGB colour constants used by the patterns.
- One natural sub-module, vga_axis_counter: a parameterised wrap counter with enable, a wrap-out flag and a sync-window decode, instantiated once for horizontal and once for vertical. The vertical instance's enable is the horizontal wrap-out ANDed with pix_en.

Test Plan:
- Reset: hold rst_n=0, toggle clk → x=0, y=0, hsync=vsync=1, display_on=1, next_frame=0, frame_count=0. Assert rst_n low asynchronously mid-line (x=300, y=100) → all outputs return to reset values before the next clk edge.
- Line timing, pix_en=1: hsync=0 for exactly 96 clks starting at x=656; display_on falls at x=640; after x=799, x=0 and y increments by 1.
- Frame timing: vsync=0 for y=490..491 (1600 clks); after (x=799, y=524), x=0 and y=0.
- Strobe: next_frame high for exactly 1 clk when (x,y) becomes (0,480); the interval between strobes is 420000 clks; frame_count steps 0→1→2; after 256 frames it wraps to 0.
- pix_en=1 every 2nd clk: counters advance at half rate; next_frame is still exactly 1 clk wide; outputs hold on pix_en=0 cycles; the strobe interval is 840000 clks.
- Non-default parameters (H_ACTIVE=8, H_FRONT=2, H_SYNC=3, H_BACK=1, V_ACTIVE=4, V_FRONT/SYNC/BACK=1): H_TOTAL=14, V_TOTAL=7; hsync at x=10..12; next_frame at (0,4).
